// File: rtl/exe_hazard_ctrl_pkg.sv
// exe_pkg: shared types and helpers for the EXE-stage hazard controller.
//
// Contents:
//   REC_REG_W    - register-index width used inside the stage records
//   REG_ZERO     - architectural zero register (never forwarded, never a hazard)
//   state_t      - hazard FSM state {RUN, STALL, FLUSH}
//   stage_rec_t  - full EX record (sources, destination, control)
//   stage_tail_t - reduced MEM/WB record (destination and control only)
//   fwd_hit()    - "this older record produces the operand we need"
package exe_pkg;

    localparam int REC_REG_W = 5;

    localparam logic [REC_REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic [REC_REG_W-1:0] rs;
        logic [REC_REG_W-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
        logic [REC_REG_W-1:0] dst;
        logic                 regwrite;
        logic                 memread;
    } stage_rec_t;

    typedef struct packed {
        logic                 valid;
        logic [REC_REG_W-1:0] dst;
        logic                 regwrite;
        logic                 memread;
    } stage_tail_t;

    // A load sitting in MEM has no data yet, so the MEM path excludes loads;
    // in WB the loaded value is available and the exclusion is turned off.
    function automatic logic fwd_hit(input stage_tail_t          rec,
                                     input logic [REC_REG_W-1:0] src,
                                     input logic                 exclude_load);
        return rec.valid && rec.regwrite && !(exclude_load && rec.memread) &&
               (rec.dst != REG_ZERO) && (rec.dst == src);
    endfunction

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// exe_hazard_ctrl_if: decoder <-> hazard controller bundle.
//
// Handshake: there is no valid/ready pair here. The decoder presents one
// instruction per cycle qualified by dec_valid; the controller answers in the
// same cycle with stall. While stall=1 the decoder must hold every dec_*
// signal stable and re-present the same instruction on the next cycle.
//
// master : decoder side (drives dec_*, flush; reads stall/forwarding/state)
// slave  : hazard controller side
interface exe_hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic             dec_valid;
    logic [REG_W-1:0] dec_rs;
    logic [REG_W-1:0] dec_rt;
    logic             dec_uses_rs;
    logic             dec_uses_rt;
    logic [REG_W-1:0] dec_dst;
    logic             dec_regwrite;
    logic             dec_memread;
    logic             flush;

    logic             stall;
    logic             memAdelant_rs;
    logic             memAdelant_rt;
    logic             wbAdelant_rs;
    logic             wbAdelant_rt;
    logic             ALU_enable;
    logic [1:0]       state;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt,
               dec_dst, dec_regwrite, dec_memread, flush,
        input  stall, memAdelant_rs, memAdelant_rt, wbAdelant_rs,
               wbAdelant_rt, ALU_enable, state
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_uses_rs, dec_uses_rt,
               dec_dst, dec_regwrite, dec_memread, flush,
        output stall, memAdelant_rs, memAdelant_rt, wbAdelant_rs,
               wbAdelant_rt, ALU_enable, state
    );
endinterface

// File: rtl/exe_hazard_ctrl_fwd_match.sv
// fwd_match: forwarding select for one EX operand.
//
// Ports:
//   i_valid, i_uses - EX record valid and "operand is actually read"
//   i_src           - operand register index
//   i_mem, i_wb     - MEM and WB records
//   o_mem_sel       - take the MEM-stage ALU result
//   o_wb_sel        - take the WB-stage value (only when MEM does not match)
module fwd_match
    import exe_pkg::*;
(
    input  logic                 i_valid,
    input  logic                 i_uses,
    input  logic [REC_REG_W-1:0] i_src,
    input  stage_tail_t          i_mem,
    input  stage_tail_t          i_wb,
    output logic                 o_mem_sel,
    output logic                 o_wb_sel
);
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_valid & i_uses & fwd_hit(i_mem, i_src, 1'b1);
    assign w_wb_hit  = i_valid & i_uses & fwd_hit(i_wb,  i_src, 1'b0);

    // The younger producer (MEM) holds the newest value and wins.
    assign o_mem_sel = w_mem_hit;
    assign o_wb_sel  = w_wb_hit & ~w_mem_hit;
endmodule

// File: rtl/exe_hazard_ctrl.sv
// exe_hazard_ctrl: EXE-stage hazard controller.
//
// Tracks EX/MEM/WB destination metadata, drives the EX forwarding selects,
// inserts one bubble per load-use hazard and squashes EX on a taken branch.
//
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   bus (slave) - decode inputs, flush, stall, forwarding selects,
//                 ALU_enable and the debug FSM state
//   stall_count - saturating count of RUN->STALL transitions; exists only
//                 when EXE_HAZARD_STATS_EN is defined
//
// Optional feature macro: EXE_HAZARD_STATS_EN
module exe_hazard_ctrl
    import exe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    exe_hazard_ctrl_if.slave   bus
`ifdef EXE_HAZARD_STATS_EN
    ,
    output logic [15:0]        stall_count
`endif
);
    state_t      r_state;
    state_t      w_next_state;
    stage_rec_t  r_ex;
    stage_tail_t r_mem;
    stage_tail_t r_wb;

    stage_rec_t  w_dec_rec;
    stage_tail_t w_ex_tail;
    logic [REG_W-1:0] w_dec_rs;
    logic [REG_W-1:0] w_dec_rt;
    logic [REG_W-1:0] w_dec_dst;
    logic        w_hazard;
    logic        w_stall;
    logic        w_bubble;
    logic        w_mem_rs;
    logic        w_wb_rs;
    logic        w_mem_rt;
    logic        w_wb_rt;

    assign w_dec_rs  = bus.dec_rs;
    assign w_dec_rt  = bus.dec_rt;
    assign w_dec_dst = bus.dec_dst;

    always_comb begin
        w_dec_rec          = '0;
        w_dec_rec.valid    = bus.dec_valid;
        w_dec_rec.rs       = REC_REG_W'(w_dec_rs);
        w_dec_rec.rt       = REC_REG_W'(w_dec_rt);
        w_dec_rec.uses_rs  = bus.dec_uses_rs;
        w_dec_rec.uses_rt  = bus.dec_uses_rt;
        w_dec_rec.dst      = REC_REG_W'(w_dec_dst);
        w_dec_rec.regwrite = bus.dec_regwrite;
        w_dec_rec.memread  = bus.dec_memread;
    end

    always_comb begin
        w_ex_tail          = '0;
        w_ex_tail.valid    = r_ex.valid;
        w_ex_tail.dst      = r_ex.dst;
        w_ex_tail.regwrite = r_ex.regwrite;
        w_ex_tail.memread  = r_ex.memread;
    end

    // Load in EX whose result the ID instruction reads: data arrives one
    // cycle too late for MEM forwarding, so one bubble is needed.
    assign w_hazard = r_ex.valid & r_ex.memread & (r_ex.dst != REG_ZERO) &
                      bus.dec_valid &
                      ((bus.dec_uses_rs & (w_dec_rec.rs == r_ex.dst)) |
                       (bus.dec_uses_rt & (w_dec_rec.rt == r_ex.dst)));

    // Next state and stall. Flush overrides everything, including a hazard
    // in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        if (bus.flush) begin
            w_next_state = FLUSH;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_hazard) begin
                        w_next_state = STALL;
                        w_stall      = 1'b1;
                    end
                end
                STALL:   w_next_state = RUN;
                FLUSH:   w_next_state = RUN;
                default: w_next_state = RUN;
            endcase
        end
    end

    assign w_bubble = w_stall | bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
        end else begin
            r_state <= w_next_state;
            r_wb    <= r_mem;
            r_mem   <= w_ex_tail;
            r_ex    <= w_bubble ? '0 : w_dec_rec;
        end
    end

`ifdef EXE_HAZARD_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if ((r_state == RUN) && (w_next_state == STALL) &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    fwd_match u_fwd_rs (
        .i_valid   (r_ex.valid),
        .i_uses    (r_ex.uses_rs),
        .i_src     (r_ex.rs),
        .i_mem     (r_mem),
        .i_wb      (r_wb),
        .o_mem_sel (w_mem_rs),
        .o_wb_sel  (w_wb_rs)
    );

    fwd_match u_fwd_rt (
        .i_valid   (r_ex.valid),
        .i_uses    (r_ex.uses_rt),
        .i_src     (r_ex.rt),
        .i_mem     (r_mem),
        .i_wb      (r_wb),
        .o_mem_sel (w_mem_rt),
        .o_wb_sel  (w_wb_rt)
    );

    assign bus.stall         = w_stall;
    assign bus.memAdelant_rs = w_mem_rs;
    assign bus.memAdelant_rt = w_mem_rt;
    assign bus.wbAdelant_rs  = w_wb_rs;
    assign bus.wbAdelant_rt  = w_wb_rt;
    assign bus.ALU_enable    = r_ex.valid;
    assign bus.state         = r_state;
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl. Each driven cycle pushes the
// hand-computed outputs for that cycle; a monitor checks them mid-cycle.
// Expected word: {stall_count[15:0], stall, mem_rs, mem_rt, wb_rs, wb_rt,
//                 alu_enable, state[1:0]}
module tb_exe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    exe_hazard_ctrl_if #(.REG_W(5)) bus ();

`ifdef EXE_HAZARD_STATS_EN
    logic [15:0] stall_count;
`endif

    exe_hazard_ctrl #(.REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef EXE_HAZARD_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    logic [23:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    // Driver: one instruction slot per cycle, applied just after the edge.
    task automatic cyc(input string n, input logic rst, input logic fl,
                       input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr,
                       input logic [7:0] e, input logic [15:0] cnt);
        @(posedge clk);
        #1;
        reset            = rst;
        bus.flush        = fl;
        bus.dec_valid    = v;
        bus.dec_rs       = rs;
        bus.dec_rt       = rt;
        bus.dec_uses_rs  = urs;
        bus.dec_uses_rt  = urt;
        bus.dec_dst      = dst;
        bus.dec_regwrite = rw;
        bus.dec_memread  = mr;
        exp_q.push_back({cnt, e});
        name_q.push_back(n);
    endtask

    task automatic nop(input string n, input logic [7:0] e, input logic [15:0] cnt);
        cyc(n, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e, cnt);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [23:0] e;
        logic [7:0]  act;
        string       n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act = {bus.stall, bus.memAdelant_rs, bus.memAdelant_rt,
                       bus.wbAdelant_rs, bus.wbAdelant_rt, bus.ALU_enable, bus.state};
                total++;
                if (act !== e[7:0]) begin
                    bad++;
                    $display("FAIL %s: outputs got %b expected %b", n, act, e[7:0]);
                end
`ifdef EXE_HAZARD_STATS_EN
                total++;
                if (stall_count !== e[23:8]) begin
                    bad++;
                    $display("FAIL %s: stall_count got %0d expected %0d", n, stall_count, e[23:8]);
                end
`endif
            end
        end
    end

    initial begin
        reset            = 1'b1;
        bus.flush        = 1'b0;
        bus.dec_valid    = 1'b0;
        bus.dec_rs       = '0;
        bus.dec_rt       = '0;
        bus.dec_uses_rs  = 1'b0;
        bus.dec_uses_rt  = 1'b0;
        bus.dec_dst      = '0;
        bus.dec_regwrite = 1'b0;
        bus.dec_memread  = 1'b0;
        repeat (2) @(posedge clk);

        //                  name            rst fl v  rs  rt urs urt dst rw mr  s_mm_ww_a_st     cnt
        cyc("reset",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_00_00_0_00, 0);
        // ALU-ALU dependency
        cyc("add5_issue",     0, 0, 1, 1, 2, 1, 1, 5, 1, 0, 8'b0_00_00_0_00, 0);
        cyc("sub_issue",      0, 0, 1, 5, 3, 1, 1, 6, 1, 0, 8'b0_00_00_1_00, 0);
        nop("sub_in_ex_mem_rs",                            8'b0_10_00_1_00, 0);
        // Dependency two back
        cyc("addi5_issue",    0, 0, 1, 1, 0, 1, 0, 5, 1, 0, 8'b0_00_00_0_00, 0);
        cyc("indep_issue",    0, 0, 1, 1, 2, 1, 1, 8, 1, 0, 8'b0_00_00_1_00, 0);
        cyc("rdrt5_issue",    0, 0, 1, 9, 5, 1, 1, 10, 1, 0, 8'b0_00_00_1_00, 0);
        cyc("rdrt5_wb_rt",    0, 0, 1, 1, 0, 1, 0, 5, 1, 0, 8'b0_00_01_1_00, 0);
        // MEM priority: two producers of r5 back to back
        cyc("prodB_issue",    0, 0, 1, 2, 0, 1, 0, 5, 1, 0, 8'b0_00_00_1_00, 0);
        cyc("rd55_issue",     0, 0, 1, 5, 5, 1, 1, 11, 1, 0, 8'b0_00_00_1_00, 0);
        nop("mem_priority",                                8'b0_11_00_1_00, 0);
        nop("drain_a",                                     8'b0_00_00_0_00, 0);
        nop("drain_b",                                     8'b0_00_00_0_00, 0);
        // Load-use
        cyc("lw7_issue",      0, 0, 1, 1, 0, 1, 0, 7, 1, 1, 8'b0_00_00_0_00, 0);
        cyc("lu_stall",       0, 0, 1, 7, 2, 1, 1, 12, 1, 0, 8'b1_00_00_1_00, 0);
        cyc("lu_bubble",      0, 0, 1, 7, 2, 1, 1, 12, 1, 0, 8'b0_00_00_0_01, 1);
        nop("lu_dep_wb_rs",                                8'b0_00_10_1_00, 1);
        // Back-to-back load-use chain
        cyc("lwA_issue",      0, 0, 1, 1, 0, 1, 0, 7, 1, 1, 8'b0_00_00_0_00, 1);
        cyc("lwB_stall",      0, 0, 1, 7, 0, 1, 0, 8, 1, 1, 8'b1_00_00_1_00, 1);
        cyc("lwB_bubble",     0, 0, 1, 7, 0, 1, 0, 8, 1, 1, 8'b0_00_00_0_01, 2);
        cyc("add8_stall",     0, 0, 1, 8, 0, 1, 0, 13, 1, 0, 8'b1_00_10_1_00, 2);
        cyc("add8_bubble",    0, 0, 1, 8, 0, 1, 0, 13, 1, 0, 8'b0_00_00_0_01, 3);
        nop("add8_wb_rs",                                  8'b0_00_10_1_00, 3);
        // Register zero
        cyc("add0_issue",     0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 8'b0_00_00_0_00, 3);
        cyc("rd0_issue",      0, 0, 1, 0, 0, 1, 1, 14, 1, 0, 8'b0_00_00_1_00, 3);
        cyc("lw0_issue",      0, 0, 1, 2, 0, 1, 0, 0, 1, 1, 8'b0_00_00_1_00, 3);
        cyc("lw0_no_stall",   0, 0, 1, 0, 0, 1, 0, 15, 1, 0, 8'b0_00_00_1_00, 3);
        nop("r0_no_fwd",                                   8'b0_00_00_1_00, 3);
        nop("drain_c",                                     8'b0_00_00_0_00, 3);
        // Flush beats stall
        cyc("lw9_issue",      0, 0, 1, 1, 0, 1, 0, 9, 1, 1, 8'b0_00_00_0_00, 3);
        cyc("flush_vs_stall", 0, 1, 1, 9, 0, 1, 0, 16, 1, 0, 8'b0_00_00_1_00, 3);
        cyc("flush_hold",     0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0_00_00_0_10, 3);
        cyc("flush_exit",     0, 0, 1, 9, 0, 1, 0, 17, 1, 0, 8'b0_00_00_0_10, 3);
        nop("after_flush",                                 8'b0_00_00_1_00, 3);
        // Reset mid-stall
        cyc("add3_issue",     0, 0, 1, 1, 0, 1, 0, 3, 1, 0, 8'b0_00_00_0_00, 3);
        cyc("lw4_issue",      0, 0, 1, 1, 0, 1, 0, 4, 1, 1, 8'b0_00_00_1_00, 3);
        cyc("rst_lu_stall",   0, 0, 1, 4, 3, 1, 1, 18, 1, 0, 8'b1_00_00_1_00, 3);
        cyc("rst_in_stall",   1, 0, 1, 4, 3, 1, 1, 18, 1, 0, 8'b0_00_00_0_01, 4);
        cyc("rst_released",   0, 0, 1, 4, 3, 1, 1, 18, 1, 0, 8'b0_00_00_0_00, 0);
        nop("post_rst_nofwd",                              8'b0_00_00_1_00, 0);
        nop("final_idle",                                  8'b0_00_00_0_00, 0);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_hazard_ctrl.md
# exe_hazard_ctrl

Pipeline hazard controller for the EXE stage. Tracks destination-register metadata for the instructions in EX, MEM and WB and drives the EXE forwarding selects (`memAdelant_rs/rt`, `wbAdelant_rs/rt`) and `ALU_enable`. Detects load-use hazards and inserts one-cycle bubbles, and applies branch flushes. Sits beside the ID/EX pipeline register and is fed by the decoder.

## Interface

**Parameters**
- `REG_W`, 5: register-index width.

**Ports**
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `dec_valid` input 1: the ID stage holds a real instruction.
- `dec_rs`, `dec_rt` input REG_W: source registers of the ID instruction.
- `dec_uses_rs`, `dec_uses_rt` input 1: the instruction actually reads rs / rt.
- `dec_dst` input REG_W: destination register, already RegDst-resolved.
- `dec_regwrite` input 1: the instruction writes the register file.
- `dec_memread` input 1: the instruction is a load.
- `flush` input 1: branch resolved taken; squash younger instructions.
- `stall` output 1: hold PC and IF/ID this cycle.
- `memAdelant_rs`, `memAdelant_rt` output 1: EX operand takes the MEM-stage ALU result.
- `wbAdelant_rs`, `wbAdelant_rt` output 1: EX operand takes the WB-stage value.
- `ALU_enable` output 1: the EX record is valid.
- `state` output 2: FSM state, for debug.
- `stall_count` output 16: present only with `EXE_HAZARD_STATS_EN`.

## Operation

- Three internal records, EX, MEM and WB. Each holds {valid, rs, rt, uses_rs, uses_rt, dst, regwrite, memread}. MEM and WB only need {valid, dst, regwrite, memread}.
- **Advance, every edge:** WB<=MEM, MEM<=EX. EX is loaded with the decode inputs, or with a bubble (valid=0) when stalling or flushing.
- **Load-use hazard (combinational):** asserted when all of the following hold:
  - EX.valid and EX.memread and EX.dst != 0;
  - dec_valid;
  - (dec_uses_rs and dec_rs == EX.dst) or (dec_uses_rt and dec_rt == EX.dst).
- **FSM states:** RUN=0, STALL=1, FLUSH=2.
  - RUN, hazard and !flush → STALL. `stall`=1 and a bubble enters EX.
  - STALL → RUN unconditionally. The load is now in MEM, and the dependant enters EX next cycle, served by WB forwarding. One bubble per hazard, never more.
  - Any state, flush=1 → FLUSH. A bubble enters EX and `stall`=0. Flush beats stall.
  - FLUSH → RUN, provided flush has dropped; if flush is still high, stay in FLUSH.
  - A new hazard detected in STALL's exit cycle re-enters STALL.
- **Forwarding (combinational, from the EX record):**
  - `memAdelant_rs` = EX.valid & EX.uses_rs & MEM.valid & MEM.regwrite & !MEM.memread & MEM.dst != 0 & MEM.dst == EX.rs.
  - `wbAdelant_rs` = same terms against WB, with no memread exclusion, ANDed with !`memAdelant_rs`. MEM has priority.
  - rt outputs are identical, using EX.rt / uses_rt.
  - Register 0 is never forwarded.
- `ALU_enable` = EX.valid.

## Timing

- **Reset:** all records invalid, state=RUN. `stall`, all forwarding outputs, `ALU_enable` and `stall_count` are 0.
- Reset asserted mid-stall or mid-flush wins. RUN is reached on the next edge with no residual bubble.
- `stall` and the forwarding outputs are combinational from registered state plus the decode inputs. They are valid within the same cycle, with zero-cycle latency.
- Record advance and the FSM update on the same edge.
- While `stall`=1, the decode inputs are required to stay stable. The upstream holds IF/ID.

## Configuration

- **`EXE_HAZARD_STATS_EN` defined:** the `stall_count` port and register exist.
  - Increments on each edge where state is RUN and the RUN→STALL transition is taken.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- **Not defined:** the port and counter are absent. All other behaviour is identical.

## Structure

- **Shared package `exe_pkg`:**
  - `stage_rec_t` struct;
  - state enum `{RUN, STALL, FLUSH}`;
  - `REG_ZERO` constant.
- **One sub-module `fwd_match`:** compares a single operand against the MEM and WB records and outputs {mem_sel, wb_sel}. It is instantiated twice, for rs and rt.
- The FSM and record registers live in the top.

## Test plan

- **ALU-ALU dependency.** Sequence: `add` with dst=5, then `sub` with rs=5. When `sub` is in EX → `memAdelant_rs`=1, `wbAdelant_rs`=0, `stall`=0.
- **Dependency two back.** dst=5, an independent instruction, then a reader with rt=5 → `wbAdelant_rt`=1 and `memAdelant_rt`=0. Check MEM priority separately: when both MEM and WB have dst=5, only `memAdelant` is 1.
- **Load-use.** A `lw` with dst=7 in EX while ID reads rs=7:
  - `stall`=1 for exactly 1 cycle, with state RUN→STALL→RUN;
  - the EX bubble has `ALU_enable`=0;
  - next cycle the dependant is in EX with `wbAdelant_rs`=1;
  - `stall_count`=1 when `EXE_HAZARD_STATS_EN` is defined.
- **Register zero.** `add` with dst=0 followed by a reader with rs=0 → all forwarding outputs 0. A load with dst=0 → no stall.
- **Flush beats stall.** Load-use hazard and `flush`=1 in the same cycle:
  - `stall`=0 and state goes to FLUSH;
  - EX gets a bubble;
  - `stall_count` is unchanged.
- **Reset mid-stall.** Assert `reset` during STALL → next cycle state=RUN and all outputs 0. The first instruction after release has no forwarding.
